pipelined_integer_datapath: RTL and testbench
=============================================

// Module: pipelined_integer_datapath
// PURPOSE
//  Parametrised successor of the 16-bit integer datapath: register file, S-operand mux (register or DS), ALU.
//  Two-stage pipeline: EX (read/mux/ALU, results registered) then WB (register-file write).
//  WB-to-EX bypass, V (overflow) flag, flag-update enable and a valid qualifier on issue and result.
//  Sits under the control unit / sequencer; one operation may issue per clock.
// PARAMETERS
//  DATA_W  16  operand, result and register width (>=4)
//  REG_CNT 8   number of general registers (power of 2, >=2)
//  ADR_W   $clog2(REG_CNT)  register address width (derived localparam, not overridable)
// PORTS
//  clk       in   1       single clock, rising edge
//  reset     in   1       asynchronous, active-low reset
//  in_valid  in   1       issue qualifier; all other inputs are ignored when 0
//  W_en      in   1       write the result to register W_Adr (at WB)
//  W_Adr     in   ADR_W   destination register
//  R_Adr     in   ADR_W   R operand register
//  S_Adr     in   ADR_W   S operand register
//  S_Sel     in   1       1: S operand = DS; 0: S operand = reg[S_Adr]
//  DS        in   DATA_W  external data / immediate
//  ALU_OP    in   4       operation code (package enum)
//  flag_en   in   1       update N, Z, C, V with this operation
//  out_valid out  1       Alu_Out / Reg_Out hold a new result this cycle
//  Alu_Out   out  DATA_W  registered ALU result
//  Reg_Out   out  DATA_W  registered R operand (after bypass)
//  N,Z,C,V   out  1       registered status flags
// BEHAVIOUR
//  Reset (reset=0, asynchronous): all registers, Alu_Out, Reg_Out, flags, out_valid and the WB stage clear to 0.
//   A pending writeback is discarded. The block resumes on the first rising clk edge after release.
//  EX (edge where in_valid=1):
//   - Read R and S.
//   - Apply the bypass.
//   - Select S by S_Sel.
//   - Compute the result.
//   - Register Alu_Out and Reg_Out; out_valid=1 next cycle.
//   - Capture the WB entry {W_en, W_Adr, result}.
//  Latency: result and flags appear 1 cycle after issue; the register file is written at the following edge (2 cycles).
//  in_valid=0: out_valid=0 next cycle; Alu_Out, Reg_Out and flags hold; the WB entry is invalidated (no write).
//   Any already-captured WB entry still completes.
//  Bypass: if the WB entry is valid with W_en=1 and W_Adr equals R_Adr (or S_Adr with S_Sel=0), use the WB data, not the array.
//   Back-to-back dependent operations therefore see the newest value; there are no stalls.
//  Flags: update only when in_valid & flag_en; otherwise hold. N = result MSB; Z = (result == 0).
//  Opcodes (unsigned DATA_W arithmetic, results wrap modulo 2^DATA_W):
//   0 PASS_R  1 PASS_S  2 ADD R+S  3 SUB R-S  4 INC R  5 DEC R  6 AND  7 OR
//   8 XOR     9 NOT R   A SHL R    B SHR R    C ASR R  D NEG R  E ZERO F ONES
//  C flag:
//   - ADD, INC: carry out.
//   - SUB, DEC, NEG: carry out of R + ~S + 1, i.e. 1 = no borrow. DEC uses S=1; NEG computes 0 - R.
//   - Shifts: the bit shifted out.
//   - All others: 0.
//  V flag: signed overflow for ADD, SUB, INC, DEC and NEG; 0 for all others.
//  Register writes occur only from WB; no external write port. Two successive writes to one address: the later one wins.
// STRUCTURE
//  Shared package dp_pkg: ALU opcode enum/localparams, flag bit indices.
//  Sub-module dp_regfile: REG_CNT x DATA_W array with 2 asynchronous read ports, 1 synchronous write port and async active-low clear.
//   Bypass muxes and ALU stay in this module.
// TESTING (DATA_W=16, REG_CNT=8)
//  1 Write values, pulse reset low mid-stream with a WB pending
//    -> all outputs 0 immediately; later reads of every register return 0x0000.
//  2 Issue PASS_S DS=0x1234 S_Sel=1 W_en W_Adr=1; next cycle PASS_R R_Adr=1
//    -> second Reg_Out=0x1234 via the bypass; the array holds 0x1234 afterwards.
//  3 ADD R=0xFFFF S=0x0001 flag_en=1 -> Alu_Out=0x0000, Z=1 C=1 N=0 V=0.
//  4 SUB R=0x8000 S=0x0001 flag_en=1 -> Alu_Out=0x7FFF, V=1 C=1 N=0 Z=0.
//  5 SHR R=0x0001 with flag_en=0 after test 4 -> Alu_Out=0x0000; flags hold (V=1 C=1 Z=0).
//  6 in_valid=0 with W_en=1 W_Adr=2 DS=0xBEEF -> out_valid=0, outputs hold, reg2 unchanged.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the pipelined integer datapath: ALU opcodes and status-flag bit positions.
package dp_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_PASS_R = 4'h0,
    OP_PASS_S = 4'h1,
    OP_ADD    = 4'h2,
    OP_SUB    = 4'h3,
    OP_INC    = 4'h4,
    OP_DEC    = 4'h5,
    OP_AND    = 4'h6,
    OP_OR     = 4'h7,
    OP_XOR    = 4'h8,
    OP_NOT    = 4'h9,
    OP_SHL    = 4'hA,
    OP_SHR    = 4'hB,
    OP_ASR    = 4'hC,
    OP_NEG    = 4'hD,
    OP_ZERO   = 4'hE,
    OP_ONES   = 4'hF
  } alu_op_e;

  // Bit positions inside the packed {N, Z, C, V} flag register.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/dp_regfile.sv
// General register array: two asynchronous read ports, one synchronous write port, async clear.
module dp_regfile #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int ADR_W   = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADR_W-1:0]  i_w_adr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic [ADR_W-1:0]  i_ra_adr,
  input  logic [ADR_W-1:0]  i_rb_adr,
  output logic [DATA_W-1:0] o_ra_data,
  output logic [DATA_W-1:0] o_rb_data
);

  logic [DATA_W-1:0] r_mem [REG_CNT];

  // NOTE: the array is cleared on reset because software relies on zeroed registers,
  // which forces flops instead of a RAM macro; drop the reset if that ever changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_w_adr] <= i_w_data;
    end
  end

  assign o_ra_data = r_mem[i_ra_adr];
  assign o_rb_data = r_mem[i_rb_adr];

endmodule

// File: rtl/pipelined_integer_datapath.sv
// Two-stage integer datapath: EX (read, bypass, S-mux, ALU, registered outputs) then WB (register write).
module pipelined_integer_datapath
  import dp_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int REG_CNT = 8,
  localparam int ADR_W   = $clog2(REG_CNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                W_en,
  input  logic [ADR_W-1:0]    W_Adr,
  input  logic [ADR_W-1:0]    R_Adr,
  input  logic [ADR_W-1:0]    S_Adr,
  input  logic                S_Sel,
  input  logic [DATA_W-1:0]   DS,
  input  logic [ALU_OP_W-1:0] ALU_OP,
  input  logic                flag_en,
  output logic                out_valid,
  output logic [DATA_W-1:0]   Alu_Out,
  output logic [DATA_W-1:0]   Reg_Out,
  output logic                N,
  output logic                Z,
  output logic                C,
  output logic                V
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic              r_wb_valid;
  logic [ADR_W-1:0]  r_wb_adr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_alu_out;
  logic [DATA_W-1:0] r_reg_out;
  logic [3:0]        r_flags;

  logic [DATA_W-1:0] w_rf_r, w_rf_s;
  logic [DATA_W-1:0] w_r, w_s;
  alu_op_e           w_op;
  logic [DATA_W-1:0] w_add_a, w_add_b;
  logic              w_add_cin;
  logic [DATA_W:0]   w_sum;
  logic              w_add_v;
  logic [DATA_W-1:0] w_res;
  logic              w_c, w_v;

  dp_regfile #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .ADR_W  (ADR_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (reset),
    .i_we     (r_wb_valid),
    .i_w_adr  (r_wb_adr),
    .i_w_data (r_wb_data),
    .i_ra_adr (R_Adr),
    .i_rb_adr (S_Adr),
    .o_ra_data(w_rf_r),
    .o_rb_data(w_rf_s)
  );

  // The array is written on the same edge that EX reads it, so the WB entry must be forwarded.
  assign w_r  = (r_wb_valid && r_wb_adr == R_Adr) ? r_wb_data : w_rf_r;
  assign w_s  = S_Sel ? DS : ((r_wb_valid && r_wb_adr == S_Adr) ? r_wb_data : w_rf_s);
  assign w_op = alu_op_e'(ALU_OP);

  // One shared adder: subtraction-style ops feed the inverted operand with carry-in 1.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_add_a   = w_r;
    w_add_b   = w_s;
    w_add_cin = 1'b0;
    case (w_op)
      OP_SUB: begin w_add_b = ~w_s; w_add_cin = 1'b1; end
      OP_INC: w_add_b = ONE;
      OP_DEC: begin w_add_b = ~ONE; w_add_cin = 1'b1; end
      OP_NEG: begin w_add_a = '0; w_add_b = ~w_r; w_add_cin = 1'b1; end
      default: ;
    endcase
  end

  assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{DATA_W{1'b0}}, w_add_cin};
  assign w_add_v = (w_add_a[MSB] == w_add_b[MSB]) && (w_sum[MSB] != w_add_a[MSB]);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_PASS_R: w_res = w_r;
      OP_PASS_S: w_res = w_s;
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_W];
        w_v   = w_add_v;
      end
      OP_AND:  w_res = w_r & w_s;
      OP_OR:   w_res = w_r | w_s;
      OP_XOR:  w_res = w_r ^ w_s;
      OP_NOT:  w_res = ~w_r;
      OP_SHL:  begin w_res = {w_r[MSB-1:0], 1'b0};   w_c = w_r[MSB]; end
      OP_SHR:  begin w_res = {1'b0, w_r[MSB:1]};     w_c = w_r[0];   end
      OP_ASR:  begin w_res = {w_r[MSB], w_r[MSB:1]}; w_c = w_r[0];   end
      OP_ZERO: w_res = '0;
      OP_ONES: w_res = '1;
      default: w_res = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_valid  <= 1'b0;
      r_wb_adr    <= '0;
      r_wb_data   <= '0;
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_reg_out   <= '0;
      r_flags     <= '0;
    end else begin
      r_out_valid <= in_valid;
      r_wb_valid  <= in_valid & W_en;
      if (in_valid) begin
        r_alu_out <= w_res;
        r_reg_out <= w_r;
        r_wb_adr  <= W_Adr;
        r_wb_data <= w_res;
        if (flag_en) begin
          r_flags[FLAG_N] <= w_res[MSB];
          r_flags[FLAG_Z] <= (w_res == '0);
          r_flags[FLAG_C] <= w_c;
          r_flags[FLAG_V] <= w_v;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign Alu_Out   = r_alu_out;
  assign Reg_Out   = r_reg_out;
  assign N         = r_flags[FLAG_N];
  assign Z         = r_flags[FLAG_Z];
  assign C         = r_flags[FLAG_C];
  assign V         = r_flags[FLAG_V];

endmodule

// File: tb/tb_pipelined_integer_datapath.sv
// Directed + randomised bench with a behavioural register/flag model and a result scoreboard.
module tb_pipelined_integer_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        W_en = 1'b0;
  logic [2:0]  W_Adr = '0, R_Adr = '0, S_Adr = '0;
  logic        S_Sel = 1'b0;
  logic [15:0] DS = '0;
  logic [3:0]  ALU_OP = '0;
  logic        flag_en = 1'b0;
  logic        out_valid;
  logic [15:0] Alu_Out, Reg_Out;
  logic        N, Z, C, V;

  pipelined_integer_datapath #(.DATA_W(16), .REG_CNT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .W_en(W_en), .W_Adr(W_Adr),
    .R_Adr(R_Adr), .S_Adr(S_Adr), .S_Sel(S_Sel), .DS(DS), .ALU_OP(ALU_OP),
    .flag_en(flag_en), .out_valid(out_valid), .Alu_Out(Alu_Out), .Reg_Out(Reg_Out),
    .N(N), .Z(Z), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        n, z, c, v;
  } alu_t;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] rop;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;
  logic [15:0] last_alu, last_reg;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU written from the opcode table with integer arithmetic.
  function automatic alu_t model(input logic [3:0] op, input logic [15:0] r, input logic [15:0] s);
    alu_t        o;
    int          sr, ss, si;
    int unsigned u;
    sr = int'($signed(r));
    ss = int'($signed(s));
    o  = '0;
    case (op)
      4'h0: o.res = r;
      4'h1: o.res = s;
      4'h2: begin
        u = 32'(r) + 32'(s); o.res = u[15:0]; o.c = (u > 32'hFFFF);
        si = sr + ss; o.v = (si > 32767) || (si < -32768);
      end
      4'h3: begin
        o.res = r - s; o.c = (r >= s);
        si = sr - ss; o.v = (si > 32767) || (si < -32768);
      end
      4'h4: begin o.res = r + 16'd1; o.c = (r == 16'hFFFF); o.v = (r == 16'h7FFF); end
      4'h5: begin o.res = r - 16'd1; o.c = (r != 16'h0000); o.v = (r == 16'h8000); end
      4'h6: o.res = r & s;
      4'h7: o.res = r | s;
      4'h8: o.res = r ^ s;
      4'h9: o.res = ~r;
      4'hA: begin o.res = r << 1; o.c = r[15]; end
      4'hB: begin o.res = r >> 1; o.c = r[0]; end
      4'hC: begin o.res = $signed(r) >>> 1; o.c = r[0]; end
      4'hD: begin o.res = 16'd0 - r; o.c = (r == 16'h0000); o.v = (r == 16'h8000); end
      4'hE: o.res = 16'h0000;
      default: o.res = 16'hFFFF;
    endcase
    o.n = o.res[15];
    o.z = (o.res == 16'h0000);
    return o;
  endfunction

  task automatic step(input string tag, input logic v, input logic we, input logic [2:0] wa,
                      input logic [2:0] ra, input logic [2:0] sa, input logic ss,
                      input logic [15:0] ds, input logic [3:0] op, input logic fe);
    alu_t        a;
    exp_t        e;
    logic [15:0] r, s;
    in_valid = v; W_en = we; W_Adr = wa; R_Adr = ra; S_Adr = sa;
    S_Sel = ss; DS = ds; ALU_OP = op; flag_en = fe;
    if (v) begin
      r = m_regs[ra];
      s = ss ? ds : m_regs[sa];
      a = model(op, r, s);
      if (fe) m_flags = {a.n, a.z, a.c, a.v};
      sb.push_back('{alu: a.res, rop: r});
      if (we) m_regs[wa] = a.res;
    end
    @(posedge clk);
    #1;
    check({tag, "/out_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      if (sb.size() == 0) begin
        check({tag, "/sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "/alu"}, 32'(Alu_Out), 32'(e.alu));
        check({tag, "/reg"}, 32'(Reg_Out), 32'(e.rop));
        last_alu = e.alu;
        last_reg = e.rop;
      end
    end else begin
      check({tag, "/alu_hold"}, 32'(Alu_Out), 32'(last_alu));
      check({tag, "/reg_hold"}, 32'(Reg_Out), 32'(last_reg));
    end
    check({tag, "/flags"}, 32'({N, Z, C, V}), 32'(m_flags));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_flags  = 4'b0000;
    last_alu = 16'h0000;
    last_reg = 16'h0000;
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/alu"},       32'(Alu_Out),   32'd0);
    check({tag, "/reg"},       32'(Reg_Out),   32'd0);
    check({tag, "/flags"},     32'({N, Z, C, V}), 32'd0);
  endtask

  initial begin
    model_reset();

    // Reset state while held in reset.
    #12;
    check_all_zero("rst_init");
    @(negedge clk);
    reset = 1'b1;

    // Test 1: fill every register, then pulse reset with the last write still in WB.
    for (int k = 0; k < 8; k++)
      step("t1_fill", 1'b1, 1'b1, 3'(k), 3'd0, 3'd0, 1'b1, 16'hA5A0 + 16'(k), 4'h1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("t1_async");
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step("t1_read", 1'b1, 1'b0, 3'd0, 3'(k), 3'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
      check("t1_read/zero", 32'(Reg_Out), 32'h0);
    end

    // Test 2: dependent PASS_R right behind the write sees the bypassed value.
    step("t2_wr",   1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, 4'h1, 1'b0);
    step("t2_byp",  1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
    check("t2_byp/const", 32'(Reg_Out), 32'h1234);
    step("t2_idle", 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
    step("t2_arr",  1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
    check("t2_arr/const", 32'(Reg_Out), 32'h1234);

    // Test 3: 0xFFFF + 1 wraps to zero with carry.
    step("t3_wr",  1'b1, 1'b1, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFF, 4'h1, 1'b0);
    step("t3_add", 1'b1, 1'b0, 3'd0, 3'd2, 3'd0, 1'b1, 16'h0001, 4'h2, 1'b1);
    check("t3/alu",  32'(Alu_Out), 32'h0000);
    check("t3/nzcv", 32'({N, Z, C, V}), 32'b0110);

    // Test 4: 0x8000 - 1 overflows to 0x7FFF with no borrow.
    step("t4_wr",  1'b1, 1'b1, 3'd3, 3'd0, 3'd0, 1'b1, 16'h8000, 4'h1, 1'b0);
    step("t4_sub", 1'b1, 1'b0, 3'd0, 3'd3, 3'd0, 1'b1, 16'h0001, 4'h3, 1'b1);
    check("t4/alu",  32'(Alu_Out), 32'h7FFF);
    check("t4/nzcv", 32'({N, Z, C, V}), 32'b0011);

    // Test 5: SHR without flag_en leaves the SUB flags intact.
    step("t5_wr",  1'b1, 1'b1, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0001, 4'h1, 1'b0);
    step("t5_shr", 1'b1, 1'b0, 3'd0, 3'd4, 3'd0, 1'b0, 16'h0000, 4'hB, 1'b0);
    check("t5/alu",  32'(Alu_Out), 32'h0000);
    check("t5/nzcv", 32'({N, Z, C, V}), 32'b0011);

    // Test 6: a write request without in_valid must be ignored.
    step("t6_inv",  1'b0, 1'b1, 3'd2, 3'd0, 3'd0, 1'b1, 16'hBEEF, 4'h1, 1'b1);
    check("t6/alu_hold", 32'(Alu_Out), 32'h0000);
    step("t6_idle", 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
    step("t6_rd",   1'b1, 1'b0, 3'd0, 3'd2, 3'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
    check("t6/reg2", 32'(Reg_Out), 32'hFFFF);

    // Random traffic: every opcode, bypass on both operands, bubbles and same-address writes.
    for (int i = 0; i < 200; i++)
      step("rnd", ($urandom_range(0, 7) != 0), 1'($urandom), 3'($urandom), 3'($urandom),
           3'($urandom), 1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));

    step("drain", 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
    check("sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
